// File: rtl/sdm_pkg.sv
// Shared types and constants for the SDM averaging cascade scheduler.
package sdm_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      CLEAR = 2'd2
   } sched_state_e;

   localparam logic signed [15:0] SDM_POS = 16'sd32767;
   localparam logic signed [15:0] SDM_NEG = -16'sd32767;

   // Width of a stage index; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sdm_avg_engine.sv
// Shared accumulate/shift datapath for one averaging stage operation.
// SDM_SCHED_ROUND_EN selects round-half-up instead of floor on the shift.
module sdm_avg_engine #(
   parameter int DW       = 16,
   parameter int LOG2_AVG = 1
) (
   input  logic signed [DW+LOG2_AVG-1:0] acc,
   input  logic signed [DW-1:0]          pdat,
   input  logic        [LOG2_AVG-1:0]    cnt,
   output logic signed [DW+LOG2_AVG-1:0] acc_next,
   output logic        [LOG2_AVG-1:0]    cnt_next,
   output logic signed [DW-1:0]          avg,
   output logic                          emit
);
   localparam int AW = DW + LOG2_AVG;

   logic signed [AW-1:0] sum;
   logic signed [AW-1:0] rnd;

   // AW bits hold 2^LOG2_AVG full-scale samples plus the rounding half.
   assign sum = acc + AW'(pdat);

`ifdef SDM_SCHED_ROUND_EN
   localparam int HALF = 1 << (LOG2_AVG - 1);
   assign rnd = sum + AW'(HALF);
`else
   assign rnd = sum;
`endif

   assign emit     = &cnt;
   assign avg      = DW'(rnd >>> LOG2_AVG);
   assign acc_next = emit ? '0 : sum;
   assign cnt_next = emit ? '0 : cnt + 1'b1;

endmodule

// File: rtl/sdm_cascade_scheduler.sv
// Time-multiplexed decimating average cascade for a 1-bit SDM stream.
// SDM_SCHED_ROUND_EN (in sdm_avg_engine) switches stage averages to round-half-up.
//
// state | meaning
// IDLE  | no stage holds a pending sample
// RUN   | scheduler servicing pending stages, deepest first
// CLEAR | zeroing stage clr_idx, one stage per cycle
module sdm_cascade_scheduler
   import sdm_pkg::*;
#(
   parameter int N_STAGES = 6,
   parameter int LOG2_AVG = 1,
   parameter int DW       = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 valid_in,
   output logic                 ready_in,
   input  logic                 din,
   output logic                 valid_out,
   output logic signed [DW-1:0] dout,
   output logic                 busy
);
   localparam int AW = DW + LOG2_AVG;
   localparam int IW = idx_width(N_STAGES);

   sched_state_e state, state_next;
   logic [IW-1:0] clr_idx, clr_idx_next;

   logic [N_STAGES-1:0]                pend;
   logic [N_STAGES-1:0][DW-1:0]        pdat;
   logic [N_STAGES-1:0][AW-1:0]        acc;
   logic [N_STAGES-1:0][LOG2_AVG-1:0]  cnt;

   logic [IW-1:0]        sel;
   logic                 sel_vld;
   logic                 op_en;
   logic                 accept;
   logic signed [AW-1:0] acc_next;
   logic [LOG2_AVG-1:0]  cnt_next;
   logic signed [DW-1:0] avg;
   logic                 emit;

   // Highest pending stage wins; later loop iterations override earlier ones.
   always_comb begin
      sel     = '0;
      sel_vld = 1'b0;
      for (int k = 0; k < N_STAGES; k++) begin
         if (pend[k]) begin
            sel     = IW'(k);
            sel_vld = 1'b1;
         end
      end
   end

   assign ready_in = !rst && !clear && (state != CLEAR) && !pend[0];
   assign accept   = valid_in && ready_in;
   assign op_en    = sel_vld && (state != CLEAR) && !clear;
   assign busy     = (state != IDLE);

   sdm_avg_engine #(
      .DW       (DW),
      .LOG2_AVG (LOG2_AVG)
   ) u_engine (
      .acc      (acc[sel]),
      .pdat     (pdat[sel]),
      .cnt      (cnt[sel]),
      .acc_next (acc_next),
      .cnt_next (cnt_next),
      .avg      (avg),
      .emit     (emit)
   );

   always_comb begin
      state_next   = state;
      clr_idx_next = clr_idx;
      if (clear) begin
         state_next   = CLEAR;
         clr_idx_next = '0;
      end else begin
         case (state)
            IDLE: begin
               if (|pend) state_next = RUN;
            end
            RUN: begin
               if (!(|pend) && !accept) state_next = IDLE;
            end
            CLEAR: begin
               if (clr_idx == IW'(N_STAGES - 1)) begin
                  state_next   = IDLE;
                  clr_idx_next = '0;
               end else begin
                  clr_idx_next = clr_idx + 1'b1;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         clr_idx   <= '0;
         pend      <= '0;
         pdat      <= '0;
         acc       <= '0;
         cnt       <= '0;
         valid_out <= 1'b0;
         dout      <= '0;
      end else begin
         state     <= state_next;
         clr_idx   <= clr_idx_next;
         valid_out <= 1'b0;
         if (!clear) begin
            if (state == CLEAR) begin
               for (int k = 0; k < N_STAGES; k++) begin
                  if (clr_idx == IW'(k)) begin
                     pend[k] <= 1'b0;
                     pdat[k] <= '0;
                     acc[k]  <= '0;
                     cnt[k]  <= '0;
                  end
               end
            end else begin
               if (op_en) begin
                  pend[sel] <= 1'b0;
                  acc[sel]  <= acc_next;
                  cnt[sel]  <= cnt_next;
                  if (emit) begin
                     if (sel == IW'(N_STAGES - 1)) begin
                        dout      <= avg;
                        valid_out <= 1'b1;
                     end else begin
                        pend[sel + 1'b1] <= 1'b1;
                        pdat[sel + 1'b1] <= avg;
                     end
                  end
               end
               // Placed after the service clear so a new beat into stage 0 wins.
               if (accept) begin
                  pend[0] <= 1'b1;
                  pdat[0] <= din ? DW'(SDM_POS) : DW'(SDM_NEG);
               end
            end
         end
      end
   end

endmodule
